// File: rtl/noc_pkg.sv
// noc_pkg: shared flit and link-state definitions for the link receive path
package noc_pkg;
   localparam int DATA_WIDTH = 256;
   localparam int FIFO_DEPTH = 8;
   localparam int VALID_BIT  = DATA_WIDTH - 1;
   typedef enum logic [1:0] {
      LINK_DOWN  = 2'd0,
      LINK_TRAIN = 2'd1,
      LINK_UP    = 2'd2
   } link_state_e;
endpackage

// File: rtl/rx_flit_fifo.sv
// rx_flit_fifo: show-ahead flit FIFO with a registered head and occupancy-based full/empty
module rx_flit_fifo import noc_pkg::*; #(
   parameter int DataWidth = DATA_WIDTH,
   parameter int Depth     = FIFO_DEPTH,
   parameter int AddrWidth = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [DataWidth-1:0] din,
   output logic [DataWidth-1:0] head,
   output logic [AddrWidth:0]   count
);
   logic [DataWidth-1:0] mem [Depth];
   logic [AddrWidth-1:0] wr_ptr, rd_ptr, rd_next;
   logic [AddrWidth:0]   remain, count_next;
   logic [DataWidth-1:0] head_next;
   // next head: the pushed flit if nothing else remains, otherwise the entry after the popped one
   always_comb begin
      rd_next    = rd_ptr + AddrWidth'(pop);
      remain     = count - (AddrWidth+1)'(pop);
      count_next = remain + (AddrWidth+1)'(push);
      head_next  = (remain == '0) ? (push ? din : '0) : mem[rd_next];
   end
   // storage array, never reset
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end
   // pointers, occupancy and head register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         wr_ptr <= wr_ptr + AddrWidth'(push);
         rd_ptr <= rd_next;
         count  <= count_next;
         head   <= head_next;
      end
   end
endmodule

// File: rtl/link_rx_buffer.sv
// link_rx_buffer: link-state gated receive buffer feeding one switch inject port
module link_rx_buffer import noc_pkg::*; #(
   parameter int DataWidth    = DATA_WIDTH,
   parameter int Depth        = FIFO_DEPTH,
   parameter int AddrWidth    = 3,
   parameter int WarmupCycles = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DataWidth-1:0] rx_par_data,
   input  logic                 rx_ready,
   output logic [DataWidth-1:0] inject,
   output logic                 inject_receive,
   input  logic                 InjectSlotAvail,
   output logic                 credit_return,
   output logic [AddrWidth:0]   occupancy,
   output logic                 link_up,
   output logic                 overflow,
   output logic [7:0]           drop_cnt
);
   link_state_e          state, state_next;
   logic [7:0]           warm_cnt, warm_next;
   logic                 arrive, full, pop, push, drop;
   logic [DataWidth-1:0] din;
   // link-state next-state and warmup counter
   always_comb begin
      state_next = state;
      warm_next  = warm_cnt;
      case (state)
         LINK_DOWN: begin
            if (rx_ready) begin
               state_next = LINK_TRAIN;
               warm_next  = '0;
            end
         end
         LINK_TRAIN: begin
            if (!rx_ready) state_next = LINK_DOWN;
            else if (warm_cnt == 8'(WarmupCycles - 1)) state_next = LINK_UP;
            else warm_next = warm_cnt + 8'd1;
         end
         LINK_UP: begin
            if (!rx_ready) state_next = LINK_DOWN;
         end
         default: state_next = LINK_DOWN;
      endcase
   end
   // accept arrivals only while up; a full FIFO still takes a flit when the head leaves the same cycle
   always_comb begin
      arrive = (state == LINK_UP) && rx_ready && rx_par_data[DataWidth-1];
      pop    = inject_receive && InjectSlotAvail;
      full   = occupancy == (AddrWidth+1)'(Depth);
      push   = arrive && (!full || pop);
      drop   = arrive && full && !pop;
      din    = {1'b1, rx_par_data[DataWidth-2:0]};
   end
   assign inject_receive = inject[DataWidth-1];
   assign link_up        = state == LINK_UP;
   // state, credit pulse and sticky drop accounting
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= LINK_DOWN;
         warm_cnt      <= '0;
         credit_return <= 1'b0;
         overflow      <= 1'b0;
         drop_cnt      <= '0;
      end else begin
         state         <= state_next;
         warm_cnt      <= warm_next;
         credit_return <= pop;
         overflow      <= overflow | drop;
         drop_cnt      <= drop_cnt + 8'(drop && drop_cnt != 8'hFF);
      end
   end
   rx_flit_fifo #(
      .DataWidth(DataWidth),
      .Depth(Depth),
      .AddrWidth(AddrWidth)
   ) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(push),
      .pop(pop),
      .din(din),
      .head(inject),
      .count(occupancy)
   );
endmodule
